// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: two-phase pipeline, programmable wait states, two-cycle ERROR, write-to-read forwarding.
// Optional macro AHB_SLV_BYTE_LANE_EN enables sub-width writes; without it only full-width transfers are legal.
module ahb_sram_slave #(
   parameter int DATA_WIDTH  = 16,
   parameter int ADDR_WIDTH  = 16,
   parameter int MEM_DEPTH   = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic                  HCLK,
   input  logic                  RESET,
   input  logic                  HSEL,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic [DATA_WIDTH-1:0] HWDATA,
   input  logic [2:0]            HBURST,
   input  logic [2:0]            HSIZE,
   input  logic [1:0]            HTRANS,
   input  logic                  HWRITE,
   input  logic                  HMASTLOCK,
   input  logic                  HREADYIN,
   output logic [DATA_WIDTH-1:0] HRDATA,
   output logic                  HREADY,
   output logic                  HRESP
);
   localparam int BYTES = DATA_WIDTH / 8;
   localparam int OFFS  = $clog2(BYTES);
   localparam int MIDX  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

   state_t                state_q, state_d;
   logic [3:0]            waitCnt_q, waitCnt_d;
   logic                  valid_q, valid_d;
   logic                  write_q, write_d;
   logic [MIDX-1:0]       idx_q, idx_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
`ifdef AHB_SLV_BYTE_LANE_EN
   logic [OFFS-1:0]       off_q, off_d;
   logic [2:0]            size_q, size_d;
`endif

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   logic                  ready, accept, reqErr, commitWrite;
   logic [ADDR_WIDTH-1:0] reqIdx, alignMask;
   logic [MIDX-1:0]       reqMemIdx;
   logic [DATA_WIDTH-1:0] wrMask, wrData, fwdData;
   logic                  unusedInputs;

   assign unusedInputs = ^{HBURST, HMASTLOCK, HTRANS[0]};

   assign ready  = (state_q == IDLE) || (state_q == ERR2);
   assign HREADY = ready;
   assign HRESP  = (state_q == ERR1) || (state_q == ERR2);
   assign HRDATA = rdata_q;

   assign accept    = HSEL && HREADYIN && ready && HTRANS[1];
   assign reqIdx    = HADDR >> OFFS;
   assign reqMemIdx = reqIdx[MIDX-1:0];
   assign alignMask = (ADDR_WIDTH'(1) << HSIZE) - ADDR_WIDTH'(1);

   always_comb begin
      reqErr = ({1'b0, reqIdx} >= (ADDR_WIDTH+1)'(MEM_DEPTH))
            || (HSIZE > 3'(OFFS))
            || ((HADDR & alignMask) != '0);
`ifndef AHB_SLV_BYTE_LANE_EN
      if (HSIZE != 3'(OFFS)) reqErr = 1'b1;
`endif
   end

`ifdef AHB_SLV_BYTE_LANE_EN
   always_comb begin
      wrMask = '0;
      for (int b = 0; b < BYTES; b++)
         if (b >= int'(off_q) && b < int'(off_q) + (1 << size_q)) wrMask[b*8 +: 8] = 8'hFF;
   end
`else
   assign wrMask = '1;
`endif

   // A write commits on the ready edge of its data phase; a read captured on that same edge sees the merged word.
   assign commitWrite = valid_q && write_q && (state_q == IDLE);
   assign wrData      = (mem[idx_q] & ~wrMask) | (HWDATA & wrMask);
   assign fwdData     = (commitWrite && (idx_q == reqMemIdx)) ? wrData : mem[reqMemIdx];

   always_ff @(posedge HCLK) begin
      if (commitWrite) mem[idx_q] <= wrData;
   end

   always_comb begin
      state_d   = state_q;
      waitCnt_d = waitCnt_q;
      valid_d   = valid_q;
      write_d   = write_q;
      idx_d     = idx_q;
      rdata_d   = rdata_q;
`ifdef AHB_SLV_BYTE_LANE_EN
      off_d     = off_q;
      size_d    = size_q;
`endif
      case (state_q)
         IDLE, ERR2: begin
            state_d = IDLE;
            valid_d = 1'b0;
            if (accept) begin
               write_d = HWRITE;
               idx_d   = reqMemIdx;
`ifdef AHB_SLV_BYTE_LANE_EN
               off_d   = HADDR[OFFS-1:0];
               size_d  = HSIZE;
`endif
               if (reqErr) begin
                  state_d = ERR1;
                  rdata_d = '0;
               end else begin
                  valid_d = 1'b1;
                  if (WAIT_STATES > 0) begin
                     state_d   = WAIT;
                     waitCnt_d = 4'(WAIT_STATES - 1);
                  end else if (!HWRITE) begin
                     rdata_d = fwdData;
                  end
               end
            end
         end
         WAIT: begin
            if (waitCnt_q == 4'd0) begin
               state_d = IDLE;
               if (!write_q) rdata_d = mem[idx_q];
            end else begin
               waitCnt_d = waitCnt_q - 4'd1;
            end
         end
         ERR1:    state_d = ERR2;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge RESET) begin
      if (!RESET) begin
         state_q   <= IDLE;
         waitCnt_q <= '0;
         valid_q   <= 1'b0;
         write_q   <= 1'b0;
         idx_q     <= '0;
         rdata_q   <= '0;
`ifdef AHB_SLV_BYTE_LANE_EN
         off_q     <= '0;
         size_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         waitCnt_q <= waitCnt_d;
         valid_q   <= valid_d;
         write_q   <= write_d;
         idx_q     <= idx_d;
         rdata_q   <= rdata_d;
`ifdef AHB_SLV_BYTE_LANE_EN
         off_q     <= off_d;
         size_q    <= size_d;
`endif
      end
   end
endmodule
